// File: rtl/seven_segment_scanner.sv
// Multiplexed DIGITS-wide seven-segment scanner with tear-free frame loading.
// Optional build macro SEVSEG_HEX_EN: nibbles 10..15 decode as hex letters instead of a dash.
module seven_segment_scanner #(
    parameter int DIGITS     = 4,
    parameter int DIV        = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank,
    output logic                  busy,
    output logic                  frame_start,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  wrap;
    logic                  wrap_q;
    logic [4*DIGITS-1:0]   act_data;
    logic [DIGITS-1:0]     act_blank;
    logic [4*DIGITS-1:0]   pend_data;
    logic [DIGITS-1:0]     pend_blank;
    logic                  pend_v;
    logic [3:0]            cur_nib;
    logic [6:0]            seg_next;
    logic [DIGITS-1:0]     an_next;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'b0000000;
        case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
`ifdef SEVSEG_HEX_EN
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
`else
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: s = 7'b0000001;
`endif
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign tick = (pcnt == PMAX);
    assign wrap = tick && (idx == IMAX);
    assign busy = pend_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // A load landing on the wrap bypasses the pending slot; otherwise the wrap promotes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data   <= '0;
            act_blank  <= '1;
            pend_data  <= '0;
            pend_blank <= '0;
            pend_v     <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                act_data  <= data;
                act_blank <= blank;
            end else if (pend_v) begin
                act_data  <= pend_data;
                act_blank <= pend_blank;
            end
            pend_v <= 1'b0;
        end else if (load) begin
            pend_data  <= data;
            pend_blank <= blank;
            pend_v     <= 1'b1;
        end
    end

    always_comb begin
        cur_nib  = act_data[{idx, 2'b00} +: 4];
        seg_next = 7'b0000000;
        an_next  = '0;
        if (!act_blank[idx]) begin
            seg_next = decode(cur_nib);
            an_next  = DIGITS'(1) << idx;
        end
    end

    // frame_start lines up with the first registered cycle of digit 0, two edges after the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= {7{ACTIVE_LOW}};
            an          <= {DIGITS{ACTIVE_LOW}};
            wrap_q      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_next ^ {7{ACTIVE_LOW}};
            an          <= an_next ^ {DIGITS{ACTIVE_LOW}};
            wrap_q      <= wrap;
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner: an active-high and an active-low instance scan the same frames.
module tb_seven_segment_scanner;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;

    typedef struct packed {
        logic       fs;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  blank = '0;

    logic        busy_h, fs_h, busy_l, fs_l;
    logic [6:0]  seg_h, seg_l;
    logic [3:0]  an_h, an_l;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    seven_segment_scanner #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .blank(blank),
        .busy(busy_h), .frame_start(fs_h), .seg(seg_h), .an(an_h)
    );

    seven_segment_scanner #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .load(load), .data(data), .blank(blank),
        .busy(busy_l), .frame_start(fs_l), .seg(seg_l), .an(an_l)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
`ifdef SEVSEG_HEX_EN
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            4'hF: s = 7'b1000111;
`endif
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input exp_t e, input logic b);
        check({tag, "_fs_h"},   {15'b0, fs_h},   {15'b0, e.fs});
        check({tag, "_an_h"},   {12'b0, an_h},   {12'b0, e.an});
        check({tag, "_seg_h"},  {9'b0, seg_h},   {9'b0, e.seg});
        check({tag, "_busy_h"}, {15'b0, busy_h}, {15'b0, b});
        check({tag, "_fs_l"},   {15'b0, fs_l},   {15'b0, e.fs});
        check({tag, "_an_l"},   {12'b0, an_l},   {12'b0, ~e.an});
        check({tag, "_seg_l"},  {9'b0, seg_l},   {9'b0, ~e.seg});
        check({tag, "_busy_l"}, {15'b0, busy_l}, {15'b0, b});
    endtask

    task automatic wait_frame_start();
        int n = 0;
        while (fs_h !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", {15'b0, fs_h}, 16'd1);
    endtask

    // Called on the negedge where frame_start is high; checks one 16-cycle frame and
    // optionally drives up to two loads at given steps.
    task automatic apply_stimulus(input string tag, input logic [15:0] fd, input logic [3:0] fb,
                                  input int la, input logic [15:0] lda, input logic [3:0] lba,
                                  input int lb, input logic [15:0] ldb, input logic [15:0] busy_mask);
        exp_t e;
        for (int k = 0; k < DIGITS; k++) begin
            for (int c = 0; c < DIV; c++) begin
                e.fs  = (k == 0 && c == 0);
                e.an  = fb[k] ? 4'b0000 : (4'b0001 << k);
                e.seg = fb[k] ? 7'b0000000 : ref_seg(fd[4*k +: 4]);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < DIGITS * DIV; i++) begin
            e = sb.pop_front();
            check_output(tag, e, busy_mask[i]);
            load = 1'b0;
            if (i == la) begin
                load  = 1'b1;
                data  = lda;
                blank = lba;
            end
            if (i == lb) begin
                load = 1'b1;
                data = ldb;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        exp_t zero;
        zero = '0;
        $display("[TB] seven_segment_scanner test start");
        repeat (3) @(negedge clk);
        check_output("reset", zero, 1'b0);
        rst_n = 1'b1;

        wait_frame_start();
        for (int f = 0; f < 4; f++)
            apply_stimulus("idle_blank", 16'h0000, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0, 16'h0000);
        apply_stimulus("load1234", 16'h0000, 4'hF, 0, 16'h1234, 4'h0, -1, 16'h0, 16'h7FFE);
        apply_stimulus("show1234", 16'h1234, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 16'h0000);
        apply_stimulus("double_load", 16'h1234, 4'h0, 0, 16'h1111, 4'h0, 3, 16'h2222, 16'h7FFE);
        apply_stimulus("wrap_load", 16'h2222, 4'h0, 14, 16'h8888, 4'h0, -1, 16'h0, 16'h0000);
        apply_stimulus("show8888", 16'h8888, 4'h0, 0, 16'hABCD, 4'h0, -1, 16'h0, 16'h7FFE);
        apply_stimulus("showABCD", 16'hABCD, 4'h0, 0, 16'hABCD, 4'h5, -1, 16'h0, 16'h7FFE);
        apply_stimulus("blank0101", 16'hABCD, 4'h5, 0, 16'h1234, 4'h0, -1, 16'h0, 16'h7FFE);

        // Mid-slot asynchronous reset with a frame pending.
        @(negedge clk);
        load = 1'b1;
        data = 16'h5555;
        @(negedge clk);
        load = 1'b0;
        check("pending_busy", {15'b0, busy_h}, 16'd1);
        #2 rst_n = 1'b0;
        #1 check_output("async_reset", zero, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_frame_start();
        apply_stimulus("post_reset_blank", 16'h0000, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0, 16'h0000);
        check("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
